// File: rtl/ws2812_rz_decoder_if.sv
// Decoded-word stream and frame status leaving the WS2812 RZ receiver.
// Latency: n/a (signal bundle only). Backpressure: data_ready from the consumer stalls the single-entry output.
interface ws2812_rz_decoder_if;
    logic        data_valid;
    logic        data_ready;
    logic [23:0] RGB;
    logic        frame_end;
    logic [15:0] frame_len;
    logic        overflow;
    logic        err;

    modport master (
        output data_valid, RGB, frame_end, frame_len, overflow, err,
        input  data_ready
    );

    modport slave (
        input  data_valid, RGB, frame_end, frame_len, overflow, err,
        output data_ready
    );
endinterface

// File: rtl/ws2812_rz_decoder.sv
// WS2812 RZ line receiver: classifies pulse widths into bits, packs 24-bit words MSB first, flags latch gaps.
// Latency: word valid 3 clk after the pin falling edge of bit 24 (2-FF synchronizer + state update).
// Backpressure: one-entry output; a word completing while the entry is held and not accepted is dropped with overflow.
module ws2812_rz_decoder #(
    parameter int T_THRESH   = 28,
    parameter int GLITCH_CYC = 5,
    parameter int MAX_HIGH   = 100,
    parameter int RESET_CYC  = 2500
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RZ_data,
    ws2812_rz_decoder_if.master        out_if
);
    localparam logic [11:0] TH_C  = 12'(T_THRESH);
    localparam logic [11:0] GL_C  = 12'(GLITCH_CYC);
    localparam logic [11:0] MAX_C = 12'(MAX_HIGH);
    localparam logic [11:0] RST_C = 12'(RESET_CYC);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t      state;
    logic        rz_s1, rz_s2;
    logic [11:0] hcnt, lcnt;
    logic [4:0]  bit_cnt;
    logic [15:0] pix_cnt;
    logic [22:0] sreg;

    logic        data_valid_q, frame_end_q, overflow_q, err_q;
    logic [23:0] rgb_q;
    logic [15:0] frame_len_q;

    logic [11:0] hcnt_inc, lcnt_inc;
    logic [15:0] pix_inc;
    logic [23:0] word;
    logic        handshake;

    assign hcnt_inc  = (hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1;
    assign lcnt_inc  = (lcnt == 12'hFFF) ? lcnt : lcnt + 12'd1;
    assign pix_inc   = (pix_cnt == 16'hFFFF) ? pix_cnt : pix_cnt + 16'd1;
    assign word      = {sreg, (hcnt >= TH_C)};
    assign handshake = data_valid_q && out_if.data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC;
            rz_s1        <= 1'b0;
            rz_s2        <= 1'b0;
            hcnt         <= '0;
            lcnt         <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            sreg         <= '0;
            data_valid_q <= 1'b0;
            rgb_q        <= '0;
            frame_end_q  <= 1'b0;
            frame_len_q  <= '0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rz_s1       <= RZ_data;
            rz_s2       <= rz_s1;
            frame_end_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
            // A completion below overrides this clear in the same cycle.
            if (handshake)
                data_valid_q <= 1'b0;

            case (state)
                SYNC: begin
                    if (rz_s2) begin
                        lcnt <= '0;
                    end else begin
                        lcnt <= lcnt_inc;
                        if (lcnt_inc == RST_C) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            pix_cnt <= '0;
                        end
                    end
                end
                IDLE: begin
                    bit_cnt <= '0;
                    pix_cnt <= '0;
                    if (rz_s2) begin
                        hcnt  <= 12'd1;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (rz_s2) begin
                        hcnt <= hcnt_inc;
                        if (hcnt_inc == MAX_C) begin
                            err_q   <= 1'b1;
                            state   <= SYNC;
                            lcnt    <= '0;
                            bit_cnt <= '0;
                        end
                    end else if (hcnt < GL_C) begin
                        err_q   <= 1'b1;
                        state   <= SYNC;
                        lcnt    <= '0;
                        bit_cnt <= '0;
                    end else begin
                        sreg  <= word[22:0];
                        lcnt  <= 12'd1;
                        state <= LOW;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            pix_cnt <= pix_inc;
                            if (data_valid_q && !out_if.data_ready) begin
                                overflow_q <= 1'b1;
                            end else begin
                                rgb_q        <= word;
                                data_valid_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                LOW: begin
                    if (rz_s2) begin
                        hcnt  <= 12'd1;
                        state <= HIGH;
                    end else begin
                        lcnt <= lcnt_inc;
                        if (lcnt_inc == RST_C) begin
                            frame_end_q <= 1'b1;
                            frame_len_q <= pix_cnt;
                            err_q       <= (bit_cnt != 5'd0);
                            state       <= IDLE;
                            bit_cnt     <= '0;
                            pix_cnt     <= '0;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    assign out_if.data_valid = data_valid_q;
    assign out_if.RGB        = rgb_q;
    assign out_if.frame_end  = frame_end_q;
    assign out_if.frame_len  = frame_len_q;
    assign out_if.overflow   = overflow_q;
    assign out_if.err        = err_q;
endmodule
